dmem_responder: RTL and testbench

Data-memory responder on the far side of the CPU MEM-stage load/store port. It accepts one request at a time over a valid/ready handshake, applies a programmable number of wait states, and performs the RV32I access: LB/LH/LW/LBU/LHU loads with sign or zero extension, and SB/SH/SW stores with byte lanes. It returns read data and an error flag over a second valid/ready handshake. It replaces the zero-latency array behind the MEM stage, so stall logic can be exercised against realistic memory timing.

---
 rtl/dmem_responder.sv | 217 +++++++++++++++++++++
 tb/tb_dmem_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
//------------------------------------------------------------------------------
// Module   : dmem_responder
// Purpose  : RV32I data-memory responder with valid/ready request/response
//            handshakes and a fixed number of wait states before each access.
//            Optional macro DMEM_MISALIGN_TRAP_EN: fault misaligned half/word.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        busy
);

    localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        error_q;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic        access_en;
    logic        acc_write;
    logic [31:0] acc_addr;
    logic [2:0]  acc_funct3;
    logic [31:0] acc_wdata;
    logic        range_err;
    logic        f3_err;
    logic        mis_err;
    logic        acc_err;
    logic [AW-1:0] mem_idx;
    logic [31:0] rd_word;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;
    logic [3:0]  st_be;
    logic [31:0] st_data;
    logic        mem_we;

    // State register plus request latch and registered response
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            write_q  <= 1'b0;
            addr_q   <= 32'd0;
            funct3_q <= 3'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            error_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_IDLE && req_valid) begin
                write_q  <= req_write;
                addr_q   <= req_addr;
                funct3_q <= req_funct3;
                wdata_q  <= req_wdata;
            end
            if (access_en) begin
                rdata_q <= load_data;
                error_q <= acc_err;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        access_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (WAIT_STATES == 0) begin
                        access_en = 1'b1;
                        state_d   = S_RESP;
                    end else begin
                        cnt_d   = CNT_INIT;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    access_en = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_RESP);
        busy      = (state_q != S_IDLE);
        rsp_rdata = rdata_q;
        rsp_error = error_q;
    end

    // With zero wait states the access happens on the accept edge, so use the live request
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_write  = req_write;
            acc_addr   = req_addr;
            acc_funct3 = req_funct3;
            acc_wdata  = req_wdata;
        end else begin
            acc_write  = write_q;
            acc_addr   = addr_q;
            acc_funct3 = funct3_q;
            acc_wdata  = wdata_q;
        end
    end

    always_comb begin
        range_err = ({2'b00, acc_addr[31:2]} >= 32'(DEPTH_WORDS));
        if (acc_write) begin
            f3_err = (acc_funct3 >= 3'd3);
        end else begin
            f3_err = (acc_funct3 == 3'd3) || (acc_funct3 >= 3'd6);
        end
`ifdef DMEM_MISALIGN_TRAP_EN
        case (acc_funct3[1:0])
            2'b01:   mis_err = acc_addr[0];
            2'b10:   mis_err = (acc_addr[1:0] != 2'b00);
            default: mis_err = 1'b0;
        endcase
`else
        mis_err = 1'b0;
`endif
        acc_err = range_err | f3_err | mis_err;
        mem_idx = acc_addr[AW+1:2];
        rd_word = mem_q[mem_idx];

        case (acc_addr[1:0])
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = acc_addr[1] ? rd_word[31:16] : rd_word[15:0];

        case (acc_funct3)
            3'd0:    load_data = {{24{rd_byte[7]}}, rd_byte};
            3'd1:    load_data = {{16{rd_half[15]}}, rd_half};
            3'd2:    load_data = rd_word;
            3'd4:    load_data = {24'd0, rd_byte};
            3'd5:    load_data = {16'd0, rd_half};
            default: load_data = 32'd0;
        endcase
        if (acc_err || acc_write) begin
            load_data = 32'd0;
        end

        case (acc_funct3[1:0])
            2'b00: begin
                st_be   = 4'b0001 << acc_addr[1:0];
                st_data = {4{acc_wdata[7:0]}};
            end
            2'b01: begin
                st_be   = acc_addr[1] ? 4'b1100 : 4'b0011;
                st_data = {2{acc_wdata[15:0]}};
            end
            default: begin
                st_be   = 4'b1111;
                st_data = acc_wdata;
            end
        endcase
        mem_we = access_en && acc_write && !acc_err;
    end

    // Memory is deliberately not reset; rst only blocks a write on the reset edge
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (st_be[i]) begin
                    mem_q[mem_idx][8*i +: 8] <= st_data[8*i +: 8];
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
//------------------------------------------------------------------------------
// Module   : tb_dmem_responder
// Purpose  : Directed self-checking bench for dmem_responder (WAIT_STATES=2).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_funct3;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        busy;

    int          n_pass  = 0;
    int          n_total = 0;
    logic [31:0] rd;
    logic        er;
    int          n;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_funct3 (req_funct3),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_error  (rsp_error),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Present a request and return just after its accept edge
    task automatic send(input logic w, input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
        @(negedge clk);
        req_valid  = 1'b1;
        req_write  = w;
        req_addr   = a;
        req_funct3 = f;
        req_wdata  = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Edges counted from the accept edge (which is edge 1)
    task automatic wait_rsp(output int edges);
        edges = 1;
        while (!rsp_valid && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic access(input logic w, input logic [31:0] a, input logic [2:0] f,
                          input logic [31:0] d, output logic [31:0] rdata,
                          output logic err, output int edges);
        send(w, a, f, d);
        wait_rsp(edges);
        rdata = rsp_rdata;
        err   = rsp_error;
        handshake();
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 32'd0;
        req_funct3 = 3'd0;
        req_wdata  = 32'd0;
        rsp_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_busy",      {31'd0, busy},      32'd0);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rdata",     rsp_rdata,          32'd0);
        chk("reset_error",     {31'd0, rsp_error}, 32'd0);

        access(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, rd, er, n);
        chk("sw_latency", n, 3);
        chk("sw_rdata", rd, 32'd0);
        chk("sw_error", {31'd0, er}, 32'd0);
        access(1'b0, 32'h10, 3'd2, 32'd0, rd, er, n);
        chk("lw_latency", n, 3);
        chk("lw_rdata", rd, 32'hDEADBEEF);
        chk("lw_error", {31'd0, er}, 32'd0);

        access(1'b1, 32'h20, 3'd2, 32'h11223344, rd, er, n);
        access(1'b1, 32'h21, 3'd0, 32'hAAAAAA80, rd, er, n);
        chk("sb_error", {31'd0, er}, 32'd0);
        access(1'b0, 32'h21, 3'd0, 32'd0, rd, er, n);
        chk("lb_sext", rd, 32'hFFFFFF80);
        access(1'b0, 32'h21, 3'd4, 32'd0, rd, er, n);
        chk("lbu_zext", rd, 32'h00000080);
        access(1'b0, 32'h20, 3'd2, 32'd0, rd, er, n);
        chk("sb_lanes", rd, 32'h11228044);
        access(1'b0, 32'h22, 3'd1, 32'd0, rd, er, n);
        chk("lh_hi_pos", rd, 32'h00001122);
        access(1'b0, 32'h20, 3'd1, 32'd0, rd, er, n);
        chk("lh_lo_sext", rd, 32'hFFFF8044);
        access(1'b0, 32'h20, 3'd5, 32'd0, rd, er, n);
        chk("lhu_lo_zext", rd, 32'h00008044);
        access(1'b1, 32'h22, 3'd1, 32'h5555BEEF, rd, er, n);
        access(1'b0, 32'h20, 3'd2, 32'd0, rd, er, n);
        chk("sh_lanes", rd, 32'hBEEF8044);

        // Backpressure: a second request waits on req_valid while the response is stalled
        send(1'b0, 32'h10, 3'd2, 32'd0);
        wait_rsp(n);
        chk("bp_latency", n, 3);
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_addr   = 32'h20;
        req_funct3 = 3'd2;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rdata",     rsp_rdata,          32'hDEADBEEF);
            chk("bp_error",     {31'd0, rsp_error}, 32'd0);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("bp_after_hs_ready", {31'd0, req_ready}, 32'd1);
        chk("bp_after_hs_valid", {31'd0, rsp_valid}, 32'd0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("bp_second_accepted", {31'd0, busy}, 32'd1);
        wait_rsp(n);
        chk("bp_second_latency", n, 3);
        chk("bp_second_rdata", rsp_rdata, 32'hBEEF8044);
        handshake();

        access(1'b0, 32'h1000, 3'd2, 32'd0, rd, er, n);
        chk("oor_error", {31'd0, er}, 32'd1);
        chk("oor_rdata", rd, 32'd0);
        access(1'b1, 32'h10, 3'd3, 32'h0, rd, er, n);
        chk("bad_store_f3_error", {31'd0, er}, 32'd1);
        access(1'b0, 32'h10, 3'd2, 32'd0, rd, er, n);
        chk("bad_store_no_write", rd, 32'hDEADBEEF);
        access(1'b0, 32'h10, 3'd3, 32'd0, rd, er, n);
        chk("bad_load_f3_error", {31'd0, er}, 32'd1);
        chk("bad_load_f3_rdata", rd, 32'd0);
        access(1'b0, 32'h10, 3'd6, 32'd0, rd, er, n);
        chk("bad_load_f6_error", {31'd0, er}, 32'd1);

        access(1'b0, 32'h12, 3'd2, 32'd0, rd, er, n);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("mis_lw_error", {31'd0, er}, 32'd1);
        chk("mis_lw_rdata", rd, 32'd0);
`else
        chk("mis_lw_error", {31'd0, er}, 32'd0);
        chk("mis_lw_rdata", rd, 32'hDEADBEEF);
`endif
        access(1'b0, 32'h11, 3'd1, 32'd0, rd, er, n);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("mis_lh_error", {31'd0, er}, 32'd1);
        chk("mis_lh_rdata", rd, 32'd0);
`else
        chk("mis_lh_error", {31'd0, er}, 32'd0);
        chk("mis_lh_rdata", rd, 32'hFFFFBEEF);
`endif

        // Reset during WAIT must cancel the store
        access(1'b1, 32'h40, 3'd2, 32'hCAFEF00D, rd, er, n);
        send(1'b1, 32'h40, 3'd2, 32'h12345678);
        chk("mid_store_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_store_idle", {31'd0, busy}, 32'd0);
        chk("mid_store_ready", {31'd0, req_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_store_no_rsp", {31'd0, rsp_valid}, 32'd0);
        access(1'b0, 32'h40, 3'd2, 32'd0, rd, er, n);
        chk("mid_store_prior", rd, 32'hCAFEF00D);

        // Reset during RESP drops the response
        send(1'b0, 32'h40, 3'd2, 32'd0);
        wait_rsp(n);
        chk("resp_rst_valid_before", {31'd0, rsp_valid}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("resp_rst_valid_after", {31'd0, rsp_valid}, 32'd0);
        chk("resp_rst_busy", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
